// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each access runs IDLE -> ACCESS -> DONE; the granted requester's fields are
// latched at the grant edge, so later changes on its inputs are ignored.
module dmem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wd;
  logic          grant;       // requester currently being served
  logic          last_grant;  // reset to 1 so requester 0 wins the first tie
  logic          grant_vld;
  logic          grant_sel;

  // Arbitration and next-state: a tie goes to the requester not served last.
  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          grant_vld = 1'b1;
          grant_sel = ~last_grant;
        end else if (m0_req) begin
          grant_vld = 1'b1;
          grant_sel = 1'b0;
        end else if (m1_req) begin
          grant_vld = 1'b1;
          grant_sel = 1'b1;
        end
        if (grant_vld) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Latch the winner's request, then complete it: read data and ack are
  // registered at the ACCESS edge so both are visible together in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wd     <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      if (grant_vld) begin
        lat_we     <= grant_sel ? m1_we   : m0_we;
        lat_addr   <= grant_sel ? m1_addr : m0_addr;
        lat_wd     <= grant_sel ? m1_wd   : m0_wd;
        grant      <= grant_sel;
        last_grant <= grant_sel;
      end
      // Ack is high only in the cycle following ACCESS, i.e. during DONE.
      m0_ack <= (state == ACCESS) && !grant;
      m1_ack <= (state == ACCESS) &&  grant;
      if (state == ACCESS && !lat_we) begin
        if (grant) m1_rdata <= mem_rd;
        else       m0_rdata <= mem_rd;
      end
    end
  end

  // Memory port: write strobe only in ACCESS, so an async reset drops it at once.
  assign mem_we   = (state == ACCESS) && lat_we;
  assign mem_addr = lat_addr;
  assign mem_wd   = lat_wd;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-addressed memory model.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  dmem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: sync write, async read, word index from addr[7:2].
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
  assign mem_rd = mem[mem_addr[7:2]];

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later, and confirm acks are exclusive.
  task automatic tick();
    @(posedge clk);
    #1;
    chk1("ack_exclusive", m0_ack & m1_ack, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0;
    tick(); tick();

    // Reset state
    chk1 ("rst_busy", busy, 1'b0);
    chk1 ("rst_m0_ack", m0_ack, 1'b0);
    chk1 ("rst_m1_ack", m1_ack, 1'b0);
    chk32("rst_m0_rdata", m0_rdata, 32'h0);
    chk32("rst_m1_rdata", m1_rdata, 32'h0);
    chk1 ("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wd", mem_wd, 32'h0);
    reset = 1'b0;
    tick();

    // m0 writes DEADBEEF to 0x10
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wd = 32'hDEADBEEF;
    chk1("wr_idle_mem_we", mem_we, 1'b0);
    tick();
    chk1 ("wr_acc_mem_we", mem_we, 1'b1);
    chk32("wr_acc_addr", mem_addr, 32'h10);
    chk32("wr_acc_wd", mem_wd, 32'hDEADBEEF);
    chk1 ("wr_acc_busy", busy, 1'b1);
    chk1 ("wr_acc_ack", m0_ack, 1'b0);
    tick();
    chk1("wr_done_ack", m0_ack, 1'b1);
    chk1("wr_done_m1_ack", m1_ack, 1'b0);
    chk1("wr_done_mem_we", mem_we, 1'b0);
    m0_req = 0;
    tick();
    chk1 ("wr_idle_ack", m0_ack, 1'b0);
    chk1 ("wr_idle_busy", busy, 1'b0);
    chk32("wr_mem_content", mem[4], 32'hDEADBEEF);

    // m0 reads 0x10
    m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_wd = 0;
    tick();
    chk1("rd_acc_mem_we", mem_we, 1'b0);
    tick();
    chk1 ("rd_done_ack", m0_ack, 1'b1);
    chk32("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk32("rd_m1_rdata", m1_rdata, 32'h0);
    m0_req = 0;
    tick();

    // Reset again so the tie below starts from the reset last_grant
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk32("rst2_m0_rdata", m0_rdata, 32'h0);
    tick();

    // Simultaneous: m0 writes 0x11111111 to 0x20, m1 reads 0x20
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wd = 32'h11111111;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20; m1_wd = 0;
    tick();
    chk1 ("tie_first_we", mem_we, 1'b1);
    chk32("tie_first_wd", mem_wd, 32'h11111111);
    tick();
    chk1("tie_m0_ack", m0_ack, 1'b1);
    chk1("tie_m1_ack_low", m1_ack, 1'b0);
    m0_req = 0;
    tick();
    chk1("tie_idle_busy", busy, 1'b0);
    tick();
    chk1 ("tie_m1_acc_we", mem_we, 1'b0);
    chk32("tie_m1_acc_addr", mem_addr, 32'h20);
    tick();
    chk1 ("tie_m1_ack", m1_ack, 1'b1);
    chk1 ("tie_m0_ack_low", m0_ack, 1'b0);
    chk32("tie_m1_rdata", m1_rdata, 32'h11111111);
    m1_req = 0;
    tick();

    // Continuous contention: grants alternate starting with m0
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      chk1("rr_idle_busy", busy, 1'b0);
      tick();
      chk1 ("rr_acc_busy", busy, 1'b1);
      chk32("rr_acc_addr", mem_addr, (k % 2 == 0) ? 32'h10 : 32'h20);
      tick();
      chk1("rr_done_busy", busy, 1'b1);
      chk1("rr_m0_ack", m0_ack, (k % 2 == 0));
      chk1("rr_m1_ack", m1_ack, (k % 2 == 1));
      if (k % 2 == 0) chk32("rr_m0_rdata", m0_rdata, 32'hDEADBEEF);
      else            chk32("rr_m1_rdata", m1_rdata, 32'h11111111);
      tick();
    end
    m0_req = 0; m1_req = 0;
    tick();

    // m1 write to 0x40 aborted by reset during ACCESS
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wd = 32'hCAFEF00D;
    tick();
    chk1("abort_acc_we", mem_we, 1'b1);
    reset = 1'b1;
    #1;
    chk1("abort_we_drop", mem_we, 1'b0);
    chk1("abort_busy_drop", busy, 1'b0);
    tick();
    chk1 ("abort_no_ack", m1_ack, 1'b0);
    chk32("abort_mem_kept", mem[16], 32'h0);
    reset = 1'b0;
    m1_req = 0;
    chk32("abort_m1_rdata", m1_rdata, 32'h0);
    chk32("abort_m0_rdata", m0_rdata, 32'h0);
    tick();
    chk1("abort_still_no_ack", m1_ack, 1'b0);

    // Tie after reset: m0 must win again, then m1
    m0_req = 1; m0_we = 0; m0_addr = 32'h40;
    m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    tick();
    chk32("post_tie_addr", mem_addr, 32'h40);
    tick();
    chk1 ("post_m0_ack", m0_ack, 1'b1);
    chk32("post_m0_rdata", m0_rdata, 32'h0);
    m0_req = 0;
    tick(); tick(); tick();
    chk1 ("post_m1_ack", m1_ack, 1'b1);
    chk32("post_m1_rdata", m1_rdata, 32'hDEADBEEF);
    m1_req = 0;
    tick();

    // Inputs changed after the grant edge are ignored
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wd = 32'h12345678;
    tick();
    m0_addr = 32'h50; m0_wd = 32'hFFFFFFFF;
    chk32("hold_acc_addr", mem_addr, 32'h10);
    chk32("hold_acc_wd", mem_wd, 32'h12345678);
    tick();
    chk1("hold_ack", m0_ack, 1'b1);
    m0_req = 0;
    tick();
    chk32("hold_mem_10", mem[4], 32'h12345678);
    chk32("hold_mem_50", mem[20], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
